shared_port_arbiter: RTL and testbench
======================================

// Module: shared_port_arbiter
// PURPOSE
//   Two-requester arbiter/sequencer for one shared single-port resource (e.g.
//   instruction fetch vs. data access on one memory port). Grants the port to
//   one requester at a time, holds the grant for a fixed access length, returns
//   an ack, and drives the select of the 1-bit 2:1 muxes that steer the shared
//   port (sel=0 -> requester 0, sel=1 -> requester 1).
// PARAMETERS
//   ACCESS_CYCLES  3  cycles a grant is held per access; legal range >= 1
//   PRIORITY_MODE  0  0 = round-robin; 1 = fixed priority, req0 always wins
//   CNT_W          2  counter width; must satisfy 2**CNT_W >= ACCESS_CYCLES
// PORTS
//   clk     in   1  system clock, all state updates on rising edge
//   rst     in   1  asynchronous, active-high reset
//   req0    in   1  request from requester 0, held high until ack0
//   req1    in   1  request from requester 1, held high until ack1
//   grant0  out  1  requester 0 owns the port (registered)
//   grant1  out  1  requester 1 owns the port (registered)
//   ack0    out  1  one-cycle pulse: requester 0 access complete
//   ack1    out  1  one-cycle pulse: requester 1 access complete
//   sel     out  1  mux select for the shared port (registered)
//   busy    out  1  high whenever a grant is active (= grant0 | grant1)
// BEHAVIOUR
//   - Reset (async, any time): state=IDLE; grant0=grant1=ack0=ack1=busy=0;
//     sel=0; counter=0; last_served=1, so req0 wins the first contention.
//     Reset mid-access aborts it; no ack is issued for the aborted access.
//   - FSM states: IDLE, GNT0, GNT1. All outputs come from registers.
//   - IDLE: sample req0/req1 each cycle.
//       neither -> stay IDLE; sel holds its last value (no toggling).
//       one set -> go to that GNTx.
//       both, PRIORITY_MODE=0 -> grant the requester != last_served.
//       both, PRIORITY_MODE=1 -> GNT0.
//     On entry to GNTx: grantx=1, busy=1, sel=x, counter=ACCESS_CYCLES-1,
//     last_served=x.
//   - GNTx: the counter decrements each cycle. In the cycle where counter==0,
//     ackx=1 with grantx still 1. The next edge returns to IDLE (grantx=0,
//     ackx=0). ACCESS_CYCLES=1: ack is asserted in the first grant cycle.
//   - Latency: req sampled high in IDLE at edge t -> grant high from t+1;
//     ack is in cycle t+ACCESS_CYCLES. After ack there is exactly one IDLE
//     cycle before any new grant.
//   - Handshake: the requester must drop req in the cycle after its ack.
//     If req is still high in that IDLE cycle, it is a new request.
//   - req dropped during a grant: the access still runs to completion and ack
//     is still pulsed. There is no abort path.
//   - Requests arriving during a grant are not latched; they are evaluated
//     only in IDLE.
//   - Invariants: grant0 & grant1 == 0; ack only while the matching grant is
//     high; sel never changes while busy=1.
// TESTING
//   1 ACCESS_CYCLES=3, req0 pulse held to ack, req1=0 -> grant0 high 3 cycles,
//     ack0 in 3rd, sel=0, busy high 3 cycles, then IDLE.
//   2 RR mode, req0=req1=1 from reset, each dropped after its ack ->
//     grants 0,1 in order; sel 0 then 1; 1 idle cycle between grants.
//   3 RR mode, both held permanently -> grants alternate 0,1,0,1; each
//     3 cycles; ack count equal +/-1 after 40 cycles.
//   4 PRIORITY_MODE=1, both held permanently -> only grant0/ack0 ever;
//     grant1 stays 0; sel stays 0.
//   5 rst pulsed in 2nd cycle of GNT1 -> grant1/busy drop without waiting for
//     a clock edge; no ack1; sel=0; next contention goes to req0.
//   6 ACCESS_CYCLES=1, req1 only -> grant1 and ack1 in the same single cycle;
//     sel=1 and held after return to IDLE.

Source files
------------

// File: rtl/shared_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : shared_port_arbiter                                        |
// | Description : Two-requester arbiter/sequencer for one shared single-port |
// |               resource. Grants the port to one requester at a time,      |
// |               holds the grant for ACCESS_CYCLES cycles, pulses an ack in |
// |               the last grant cycle and drives the 2:1 port mux select.   |
// | Ports       : clk    - system clock (rising edge)                        |
// |               rst    - asynchronous active-high reset                    |
// |               req0/1 - requests, held high until the matching ack        |
// |               grant0/1 - requester owns the port (registered)            |
// |               ack0/1 - one-cycle access-complete pulse (registered)      |
// |               sel    - port mux select, 0 = req0, 1 = req1 (registered)  |
// |               busy   - a grant is active (registered, = grant0|grant1)   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module shared_port_arbiter #(
  parameter int ACCESS_CYCLES = 3,
  parameter int PRIORITY_MODE = 0,
  parameter int CNT_W         = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1,
  output logic ack0,
  output logic ack1,
  output logic sel,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  // Single-cycle accesses must ack in the very cycle the grant appears.
  localparam logic ACK_ON_ENTRY = (ACCESS_CYCLES == 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last_served, last_served_n;
  logic             grant0_n, grant1_n, ack0_n, ack1_n, sel_n, busy_n;
  logic             take1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_served <= 1'b1;   // req0 wins the first contention
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      sel         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last_served <= last_served_n;
      grant0      <= grant0_n;
      grant1      <= grant1_n;
      ack0        <= ack0_n;
      ack1        <= ack1_n;
      sel         <= sel_n;
      busy        <= busy_n;
    end
  end

  // Every output is computed one cycle ahead so it can come straight from a
  // flop: the ack is scheduled on the edge where the counter reaches zero.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    last_served_n = last_served;
    grant0_n      = grant0;
    grant1_n      = grant1;
    ack0_n        = 1'b0;
    ack1_n        = 1'b0;
    sel_n         = sel;
    take1         = 1'b0;

    case (state)
      IDLE: begin
        if (req0 && req1) begin
          take1 = (PRIORITY_MODE != 0) ? 1'b0 : ~last_served;
        end else begin
          take1 = req1;
        end
        if (req0 || req1) begin
          cnt_n         = CNT_LOAD;
          last_served_n = take1;
          sel_n         = take1;
          if (take1) begin
            state_n  = GNT1;
            grant1_n = 1'b1;
            ack1_n   = ACK_ON_ENTRY;
          end else begin
            state_n  = GNT0;
            grant0_n = 1'b1;
            ack0_n   = ACK_ON_ENTRY;
          end
        end
      end
      GNT0, GNT1: begin
        if (cnt == '0) begin
          state_n  = IDLE;
          grant0_n = 1'b0;
          grant1_n = 1'b0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            ack0_n = (state == GNT0);
            ack1_n = (state == GNT1);
          end
        end
      end
      default: begin
        state_n  = IDLE;
        grant0_n = 1'b0;
        grant1_n = 1'b0;
      end
    endcase

    busy_n = grant0_n | grant1_n;
  end

endmodule

`default_nettype wire

// File: tb/tb_shared_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_shared_port_arbiter                                     |
// | Description : Directed self-checking bench. Instance a = round-robin,    |
// |               3-cycle access; b = fixed priority, 3-cycle; c = 1-cycle.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_shared_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic a_req0 = 0, a_req1 = 0, a_g0, a_g1, a_ack0, a_ack1, a_sel, a_busy;
  logic b_req0 = 0, b_req1 = 0, b_g0, b_g1, b_ack0, b_ack1, b_sel, b_busy;
  logic c_req0 = 0, c_req1 = 0, c_g0, c_g1, c_ack0, c_ack1, c_sel, c_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shared_port_arbiter #(.ACCESS_CYCLES(3), .PRIORITY_MODE(0), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .req0(a_req0), .req1(a_req1),
    .grant0(a_g0), .grant1(a_g1), .ack0(a_ack0), .ack1(a_ack1),
    .sel(a_sel), .busy(a_busy));

  shared_port_arbiter #(.ACCESS_CYCLES(3), .PRIORITY_MODE(1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1),
    .grant0(b_g0), .grant1(b_g1), .ack0(b_ack0), .ack1(b_ack1),
    .sel(b_sel), .busy(b_busy));

  shared_port_arbiter #(.ACCESS_CYCLES(1), .PRIORITY_MODE(0), .CNT_W(1)) u_c (
    .clk(clk), .rst(rst), .req0(c_req0), .req1(c_req1),
    .grant0(c_g0), .grant1(c_g1), .ack0(c_ack0), .ack1(c_ack1),
    .sel(c_sel), .busy(c_busy));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {grant0, grant1, ack0, ack1, sel, busy} of instance a
  function automatic logic [5:0] a_vec();
    return {a_g0, a_g1, a_ack0, a_ack1, a_sel, a_busy};
  endfunction

  int a_n0, a_n1, b_n0, b_n1, b_g1_seen, b_sel_seen;
  logic a_prev_sel, a_prev_busy;

  initial begin
    // ---------------- reset state ----------------
    #12;
    check("reset_a_outputs", 32'(a_vec()), 32'b000000);
    check("reset_c_outputs", 32'({c_g0, c_g1, c_ack0, c_ack1, c_sel, c_busy}), 32'b0);
    rst = 1'b0;

    // ---------------- 1: single req0 access ----------------
    tick();
    a_req0 = 1'b1;
    tick(); check("t1_cycle1", 32'(a_vec()), 32'b100001);
    tick(); check("t1_cycle2", 32'(a_vec()), 32'b100001);
    tick(); check("t1_cycle3_ack", 32'(a_vec()), 32'b101001);
    a_req0 = 1'b0;
    tick(); check("t1_idle", 32'(a_vec()), 32'b000000);
    tick(); check("t1_idle2", 32'(a_vec()), 32'b000000);

    // ---------------- 2: contention from reset, RR ----------------
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    a_req0 = 1'b1; a_req1 = 1'b1;
    tick(); check("t2_g0_first", 32'(a_vec()), 32'b100001);
    tick();
    tick(); check("t2_ack0", 32'(a_vec()), 32'b101001);
    a_req0 = 1'b0;
    tick(); check("t2_gap_idle", 32'(a_vec()), 32'b000000);
    tick(); check("t2_g1", 32'(a_vec()), 32'b010011);
    tick(); check("t2_g1_c2", 32'(a_vec()), 32'b010011);
    tick(); check("t2_ack1", 32'(a_vec()), 32'b010111);
    a_req1 = 1'b0;
    tick(); check("t2_idle_sel_held", 32'(a_vec()), 32'b000010);
    tick(); check("t2_idle_sel_held2", 32'(a_vec()), 32'b000010);

    // ---------------- 3 & 4: both held 40 cycles, RR (a) and fixed (b) ----
    // a's last_served is 1 here, so the sequence starts with requester 0.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    a_n0 = 0; a_n1 = 0; b_n0 = 0; b_n1 = 0; b_g1_seen = 0; b_sel_seen = 0;
    a_prev_sel = a_sel; a_prev_busy = a_busy;
    a_req0 = 1'b1; a_req1 = 1'b1; b_req0 = 1'b1; b_req1 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (a_ack0) a_n0++;
      if (a_ack1) a_n1++;
      if (b_ack0) b_n0++;
      if (b_ack1) b_n1++;
      if (b_g1) b_g1_seen++;
      if (b_sel) b_sel_seen++;
      check($sformatf("t3_exclusive_%0d", i), 32'(a_g0 & a_g1), 32'd0);
      if (a_prev_busy && a_busy)
        check($sformatf("t3_sel_stable_%0d", i), 32'(a_sel), 32'(a_prev_sel));
      a_prev_sel = a_sel; a_prev_busy = a_busy;
      if (i == 5) check("t3_second_is_g1", 32'(a_vec()), 32'b010011);
      if (i == 9) check("t3_third_is_g0", 32'(a_vec()), 32'b100001);
    end
    check("t3_ack0_count", 32'(a_n0), 32'd5);
    check("t3_ack1_count", 32'(a_n1), 32'd5);
    check("t4_ack0_count", 32'(b_n0), 32'd10);
    check("t4_ack1_count", 32'(b_n1), 32'd0);
    check("t4_grant1_never", 32'(b_g1_seen), 32'd0);
    check("t4_sel_never", 32'(b_sel_seen), 32'd0);
    a_req0 = 1'b0; a_req1 = 1'b0; b_req0 = 1'b0; b_req1 = 1'b0;
    tick(); check("t3_end_idle", 32'(a_vec()), 32'b000010);

    // ---------------- 5: async reset in 2nd cycle of GNT1 ----------------
    a_req1 = 1'b1;
    tick(); check("t5_g1_c1", 32'(a_vec()), 32'b010011);
    tick(); check("t5_g1_c2", 32'(a_vec()), 32'b010011);
    #2 rst = 1'b1;
    #1 check("t5_async_drop", 32'(a_vec()), 32'b000000);
    #1 rst = 1'b0;
    a_req1 = 1'b0;
    tick(); check("t5_no_ack1", 32'(a_vec()), 32'b000000);
    a_req0 = 1'b1; a_req1 = 1'b1;
    tick(); check("t5_contention_g0", 32'(a_vec()), 32'b100001);
    a_req0 = 1'b0; a_req1 = 1'b0;
    tick(); tick(); tick();

    // ---------------- 6: ACCESS_CYCLES=1, req1 only ----------------
    c_req1 = 1'b1;
    tick(); check("t6_grant_ack", 32'({c_g0, c_g1, c_ack0, c_ack1, c_sel, c_busy}), 32'b010111);
    c_req1 = 1'b0;
    tick(); check("t6_idle_sel1", 32'({c_g0, c_g1, c_ack0, c_ack1, c_sel, c_busy}), 32'b000010);
    tick(); check("t6_idle_sel1b", 32'({c_g0, c_g1, c_ack0, c_ack1, c_sel, c_busy}), 32'b000010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
